// File: rtl/dice_pkg.sv
// Shared types for the dice roll scheduler: die face width, face type and scheduler states.
// TUMBLE is always declared; it is only reachable when DICE_TUMBLE_EN is defined.
package dice_pkg;

  localparam int DIE_W = 5;

  typedef logic [DIE_W-1:0] face_t;

  typedef enum logic [1:0] {
    IDLE,
    TUMBLE,
    CAPTURE,
    HOLD
  } sched_state_t;

  // Faces run 1..top and wrap back to 1.
  function automatic face_t next_face(input face_t cur, input face_t top);
    return (cur >= top) ? face_t'(1) : cur + face_t'(1);
  endfunction

endpackage

// File: rtl/dice_face_counter.sv
// Free-running die face counter: 1 after reset, then 2..SIDES,1,2,... one step per clock.
module dice_face_counter
  import dice_pkg::*;
#(
  parameter int SIDES = 12
) (
  input  logic  clk,
  input  logic  reset,
  output face_t face
);

  always_ff @(posedge clk) begin
    if (reset) begin
      face <= face_t'(1);
    end else begin
      face <= next_face(face, face_t'(SIDES));
    end
  end

endmodule

// File: rtl/dice_roll_sched.sv
// Round-robin roll scheduler sharing one face counter among NUM_PLAYERS buttons.
// Optional macro DICE_TUMBLE_EN inserts a TUMBLE state that spins the displayed face before capture.
module dice_roll_sched
  import dice_pkg::*;
#(
  parameter int NUM_PLAYERS   = 4,
  parameter int SIDES         = 12,
  parameter int HOLD_CYCLES   = 1024,
  parameter int TUMBLE_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PLAYERS-1:0]         req,
  output logic [NUM_PLAYERS-1:0]         grant,
  output face_t                          result,
  output logic [$clog2(NUM_PLAYERS)-1:0] result_player,
  output logic                           result_valid,
  output logic                           busy
);

  localparam int PW = $clog2(NUM_PLAYERS);
  localparam logic [PW:0] N_EXT = (PW+1)'(NUM_PLAYERS);
  localparam int CNT_MAX = (HOLD_CYCLES > TUMBLE_CYCLES) ? HOLD_CYCLES : TUMBLE_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TUMBLE_LOAD = CNT_W'(TUMBLE_CYCLES - 1);

  face_t                   face;
  logic [NUM_PLAYERS-1:0]  req_q;
  logic [NUM_PLAYERS-1:0]  req_edge;
  logic [NUM_PLAYERS-1:0]  pending;
  logic [PW-1:0]           ptr;
  logic [PW-1:0]           ptr_next;
  logic [PW-1:0]           win_c;
  logic [PW-1:0]           win_idx;
  logic                    any_pending;
  logic [PW:0]             cand;
  logic [PW:0]             wrap;
  logic [CNT_W-1:0]        cnt;
  sched_state_t            state;
  sched_state_t            next_state;
  logic                    start_roll;
  logic                    capture;
  logic                    spin;
  logic                    hold_done;

  dice_face_counter #(
    .SIDES (SIDES)
  ) u_face (
    .clk   (clk),
    .reset (reset),
    .face  (face)
  );

  // req_q follows req even in reset so a button held through reset never looks like a new press.
  always_ff @(posedge clk) begin
    req_q <= req;
  end

  assign req_edge = req & ~req_q;

  // Search upward from ptr with wrap; iterating from the far end lets the nearest candidate win.
  always_comb begin
    win_c       = '0;
    any_pending = 1'b0;
    cand        = '0;
    wrap        = '0;
    for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (pending[cand[PW-1:0]]) begin
        win_c       = cand[PW-1:0];
        any_pending = 1'b1;
      end
    end
    wrap = {1'b0, win_c} + (PW+1)'(1);
    if (wrap >= N_EXT) wrap = wrap - N_EXT;
    ptr_next = wrap[PW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (any_pending) begin
`ifdef DICE_TUMBLE_EN
          next_state = TUMBLE;
`else
          next_state = CAPTURE;
`endif
        end
      end
      TUMBLE:  if (cnt == '0) next_state = CAPTURE;
      CAPTURE: next_state = HOLD;
      HOLD:    if (cnt == '0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    start_roll = (state == IDLE) && any_pending;
    capture    = (state == CAPTURE);
    spin       = (state == TUMBLE);
    hold_done  = (state == HOLD) && (cnt == '0);
  end

  // One down-counter serves both TUMBLE and HOLD, reloaded on entry to either.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (next_state != state) begin
      if (next_state == TUMBLE)    cnt <= TUMBLE_LOAD;
      else if (next_state == HOLD) cnt <= HOLD_LOAD;
      else                         cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // grant already holds the winner one-hot, so it doubles as the pending clear mask; a same-cycle new press wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending       <= '0;
      ptr           <= '0;
      win_idx       <= '0;
      grant         <= '0;
      result        <= '0;
      result_player <= '0;
      result_valid  <= 1'b0;
    end else begin
      pending      <= (pending & ~(capture ? grant : '0)) | req_edge;
      result_valid <= capture;
      if (start_roll) begin
        win_idx <= win_c;
        grant   <= NUM_PLAYERS'(1) << win_c;
        ptr     <= ptr_next;
      end else if (hold_done) begin
        grant <= '0;
      end
      if (capture) begin
        result        <= face;
        result_player <= win_idx;
      end else if (spin) begin
        result <= face;
      end
    end
  end

endmodule

// File: tb/tb_dice_roll_sched.sv
// Self-checking bench for dice_roll_sched: vector table, scoreboard of expected rolls, hand-written corner sequences.
// Define DICE_TUMBLE_EN for both RTL and bench to exercise the tumble variant.
module tb_dice_roll_sched;
  import dice_pkg::*;

  localparam int NP = 4;
  localparam int SD = 12;
  localparam int HC = 4;
  localparam int TC = 3;
`ifdef DICE_TUMBLE_EN
  localparam int TUMB = TC;
`else
  localparam int TUMB = 0;
`endif
  localparam int LAT     = 2 + TUMB;
  localparam int SPACING = LAT + HC;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [NP-1:0]           req = '0;
  logic [NP-1:0]           grant;
  face_t                   result;
  logic [$clog2(NP)-1:0]   result_player;
  logic                    result_valid;
  logic                    busy;

  dice_roll_sched #(
    .NUM_PLAYERS   (NP),
    .SIDES         (SD),
    .HOLD_CYCLES   (HC),
    .TUMBLE_CYCLES (TC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .grant         (grant),
    .result        (result),
    .result_player (result_player),
    .result_valid  (result_valid),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int player;
    int face;
    int at_edge;
  } exp_t;

  typedef struct {
    logic [NP-1:0] req;
    logic [NP-1:0] exp_grant;
    int            gap;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  int   nedge = 0;
  int   valid_cnt = 0;
  int   mptr = 0;
  exp_t sb[$];

  // Non-reset edges since the last reset, matching the face counter's notion of time.
  always @(posedge clk) begin
    if (reset) nedge <= 0;
    else       nedge <= nedge + 1;
  end

  function automatic int face_at(input int c);
    return ((c - 1) % SD) + 1;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d (edge %0d)", name, actual, expected, nedge);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive new presses while idle and queue the rolls they should produce, in round-robin order.
  task automatic applyStimulus(input logic [NP-1:0] mask);
    int e;
    int n;
    int last;
    e = nedge + 1;
    n = 0;
    last = 0;
    req = mask;
    for (int k = 0; k < NP; k++) begin
      int p;
      p = (mptr + k) % NP;
      if (mask[p]) begin
        sb.push_back('{p, face_at(e + LAT + n * SPACING), e + LAT + n * SPACING});
        last = p;
        n++;
      end
    end
    if (n > 0) mptr = (last + 1) % NP;
  endtask

  task automatic doReset(input logic [NP-1:0] held);
    req = held;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    mptr = 0;
    sb.delete();
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput("wait_idle_in_budget", (n < budget) ? 1 : 0, 1);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && result_valid) begin
      valid_cnt++;
      checkOutput("sb_has_entry", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("sb_face", int'(result), e.face);
        checkOutput("sb_player", int'(result_player), e.player);
        checkOutput("sb_edge", nedge, e.at_edge);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (bad=%0d)", bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   base;
    int   e;
    int   c;
    int   busy_cycles;

    vecs[0] = '{4'b0001, 4'b0001, 2};
    vecs[1] = '{4'b1000, 4'b1000, 5};
    vecs[2] = '{4'b0110, 4'b0010, 1};
    vecs[3] = '{4'b1001, 4'b1000, 3};
    vecs[4] = '{4'b0101, 4'b0100, 0};
    vecs[5] = '{4'b1111, 4'b0010, 7};

    // Idle counting.
    doReset('0);
    checkOutput("face_after_reset", int'(dut.u_face.face), 1);
    for (int k = 1; k <= 13; k++) begin
      tick(1);
      checkOutput("idle_face", int'(dut.u_face.face), (k % SD) + 1);
      checkOutput("idle_busy", int'(busy), 0);
      checkOutput("idle_grant", int'(grant), 0);
      checkOutput("idle_result", int'(result), 0);
    end

    // Single roll sampled at E5.
    doReset('0);
    tick(4);
    applyStimulus(4'b0100);
    c = 5 + LAT;
    tick(2);
    checkOutput("single_grant", int'(grant), 4'b0100);
    checkOutput("single_busy", int'(busy), 1);
    req = '0;
    while (nedge < c) tick(1);
`ifndef DICE_TUMBLE_EN
    checkOutput("single_result", int'(result), 7);
`endif
    checkOutput("single_player", int'(result_player), 2);
    tick(1);
    checkOutput("single_valid_one_cycle", int'(result_valid), 0);
    while (nedge < c + HC - 1) tick(1);
    checkOutput("single_busy_in_hold", int'(busy), 1);
    tick(1);
    checkOutput("single_busy_fall", int'(busy), 0);
    checkOutput("single_grant_clear", int'(grant), 0);
    waitIdle(100);

    // Vector table: presses applied while idle.
    for (int i = 0; i < 6; i++) begin
      tick(vecs[i].gap);
      applyStimulus(vecs[i].req);
      tick(2);
      checkOutput("vec_grant", int'(grant), int'(vecs[i].exp_grant));
      req = '0;
      waitIdle(200);
    end

    // Simultaneous requests with ptr at 0.
    doReset('0);
    tick(2);
    base = valid_cnt;
    e = nedge + 1;
    applyStimulus(4'b1001);
    tick(2);
    checkOutput("simul_first_grant", int'(grant), 4'b0001);
    req = '0;
    while (nedge < e + 1 + SPACING) tick(1);
    checkOutput("simul_second_grant", int'(grant), 4'b1000);
    waitIdle(100);
    checkOutput("simul_ptr", int'(dut.ptr), 0);
    checkOutput("simul_pulses", valid_cnt - base, 2);

    // Held button: through reset gives no roll, a fresh long press gives exactly one.
    doReset(4'b0010);
    base = valid_cnt;
    busy_cycles = 0;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      if (busy) busy_cycles++;
    end
    checkOutput("held_reset_pulses", valid_cnt - base, 0);
    checkOutput("held_reset_busy", busy_cycles, 0);
    req = '0;
    tick(2);
    base = valid_cnt;
    applyStimulus(4'b0010);
    tick(100);
    req = '0;
    waitIdle(100);
    checkOutput("held_press_pulses", valid_cnt - base, 1);

    // Reset in HOLD with another player queued.
    doReset('0);
    tick(1);
    e = nedge + 1;
    applyStimulus(4'b0001);
    c = e + LAT;
    tick(1);
    req = '0;
    while (nedge < c + 1) tick(1);
    req = 4'b0100;
    tick(1);
    checkOutput("midhold_queued", int'(dut.pending), 4'b0100);
    req = '0;
    reset = 1'b1;
    tick(1);
    checkOutput("midhold_busy", int'(busy), 0);
    checkOutput("midhold_grant", int'(grant), 0);
    checkOutput("midhold_result", int'(result), 0);
    checkOutput("midhold_player", int'(result_player), 0);
    checkOutput("midhold_valid", int'(result_valid), 0);
    checkOutput("midhold_pending", int'(dut.pending), 0);
    reset = 1'b0;
    mptr = 0;
    base = valid_cnt;
    tick(20);
    checkOutput("midhold_no_serve", valid_cnt - base, 0);
    checkOutput("midhold_busy_after", int'(busy), 0);

`ifdef DICE_TUMBLE_EN
    // Tumble: the display spins for TC cycles before the capture.
    doReset('0);
    tick(2);
    e = nedge + 1;
    applyStimulus(4'b0001);
    tick(2);
    req = '0;
    for (int j = 0; j < TC; j++) begin
      tick(1);
      checkOutput("tumble_spin_face", int'(result), face_at(e + 2 + j));
      checkOutput("tumble_spin_valid", int'(result_valid), 0);
    end
    waitIdle(100);
`endif

    checkOutput("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dice_roll_sched.md
# dice_roll_sched

Round-robin roll scheduler sharing one free-running die-face counter among several player buttons. It queues rising edges of each player's request and grants the die to one player at a time. It captures the counter face as that player's roll, pulses `result_valid`, then holds the result for a fixed display window before serving the next player. It sits between the debounced board buttons and the two-digit seven-segment decoder.

## Interface
- `NUM_PLAYERS`, default 4: number of requesters, 2..8.
- `SIDES`, default 12: die faces, 2..31; faces are 1..SIDES.
- `HOLD_CYCLES`, default 1024: cycles spent in HOLD, ≥1.
- `TUMBLE_CYCLES`, default 16: cycles spent in TUMBLE, ≥1; used only with the macro.
- `clk` input, 1 bit: clock clk.
- `reset` input, 1 bit: reset reset, synchronous, active-high.
- `req` input, NUM_PLAYERS bits: debounced button levels, one per player.
- `grant` output, NUM_PLAYERS bits: one-hot player owning the die; 0 in IDLE.
- `result` output, 5 bits: last captured face; 0 means no roll yet.
- `result_player` output, $clog2(NUM_PLAYERS) bits: index of the player whose roll is in `result`.
- `result_valid` output, 1 bit: one-cycle pulse when `result` is updated.
- `busy` output, 1 bit: high whenever the state is not IDLE.

## Operation
- **Face counter**
  - Increments every cycle and wraps SIDES→1.
  - Reset value is 1. After the k-th non-reset edge it equals (k mod SIDES)+1.
- **Request edge detect**
  - `req_q` registers `req` each edge, including during reset, so a button held through reset is not counted.
  - An edge is `req & ~req_q`; each edge sets `pending[i]`.
- **Arbitration**
  - `ptr` holds the highest-priority index and resets to 0.
  - The winner is the first set `pending` bit searching upward from `ptr`, wrapping.
  - After a winner is chosen, `ptr` = (winner+1) mod NUM_PLAYERS.
- **State machine**
  - IDLE: if any `pending` bit is set → CAPTURE; register `grant` (one-hot winner) and update `ptr`.
  - CAPTURE, one cycle:
    - `result` ← counter, `result_player` ← winner, `result_valid` = 1 for the following cycle.
    - Clear the winner's `pending` bit. If a new edge for the same player lands in this cycle, set wins.
    - Next state is HOLD.
  - HOLD: down-counter loaded with HOLD_CYCLES-1; at 0 → IDLE and `grant` ← 0.
- **Queuing:** requests arriving while busy are queued and served in round-robin order after HOLD. There is at most one queued roll per player.
- **Reset mid-operation:** next state is IDLE. `pending`, `grant`, `result`, `result_player`, `result_valid` and `busy` all go to 0, `ptr` to 0, and the counter to 1.

## Timing
- A request sampled high at edge E (with `req_q` = 0) → pending after E → CAPTURE entered at E+1 → `result` latched at E+2.
- `result_valid` is high in the cycle after E+2, i.e. 2 cycles of latency with the macro off.
- The captured face is the counter value present just before E+2.
- One roll occupies 2 + HOLD_CYCLES cycles (IDLE decision, CAPTURE, HOLD). The next pending player's CAPTURE starts 1 cycle after HOLD exits.
- All outputs are registered. There is no combinational path from `req` to any output.

## Configuration
- `DICE_TUMBLE_EN` defined:
  - A TUMBLE state is inserted between IDLE and CAPTURE and lasts TUMBLE_CYCLES.
  - During TUMBLE, `result` mirrors the counter every cycle ("spinning" display) with `result_valid` = 0.
  - CAPTURE then latches normally.
  - Latency becomes 2 + TUMBLE_CYCLES.
- Not defined: there is no TUMBLE state, and TUMBLE_CYCLES is ignored.

## Structure
- Package `dice_pkg` contains:
  - `DIE_W` = 5;
  - `face_t` = logic [DIE_W-1:0];
  - the state enum `sched_state_t` {IDLE, TUMBLE, CAPTURE, HOLD}. TUMBLE is always declared and only reachable with the macro.
- Sub-module `dice_face_counter` holds the 1..SIDES wrapping counter, with ports clk, reset, face.
- The scheduler FSM, edge detect and arbiter stay in `dice_roll_sched`.

## Test plan
All scenarios use NUM_PLAYERS=4, SIDES=12, HOLD_CYCLES=4, with the macro off unless stated. Edges are counted from the first non-reset edge E1.

1. **Idle counting:** reset, then no requests for 13 edges → counter reads 2..12,1,2; `result`=0, `busy`=0, `grant`=0.
2. **Single roll:** `req[2]` rises and is sampled at E5 → `grant`=0100 after E6; `result`=7, `result_player`=2 after E7; `result_valid` high one cycle; `busy` falls after HOLD.
3. **Simultaneous requests:** `req[0]` and `req[3]` both sampled at the same edge with `ptr`=0 → player 0 served first, player 3 captured 1 cycle after HOLD ends; final `ptr`=0; exactly two `result_valid` pulses.
4. **Held button:** `req[1]` held high for 100 cycles, including through a prior reset → exactly one roll (or zero if held from reset).
5. **Reset mid-HOLD:** assert reset during HOLD → next cycle `busy`=0, `grant`=0, `result`=0, `pending`=0; the previously queued player is not served.
6. **Tumble (`DICE_TUMBLE_EN`, TUMBLE_CYCLES=3):** a single request → `result` changes on 3 consecutive cycles with `result_valid`=0, then one valid pulse at latency 5.
